// File: rtl/wordle_game_ctrl_if.sv
// Front-end / display bundle for the Wordle controller: player inputs in,
// state flags, guess buffer and scoring results out.
interface wordle_game_ctrl_if #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 8
);
  localparam int CW = $clog2(WORD_LEN+1);

  logic                         Start;
  logic                         Ack;
  logic [WORD_LEN*LETTER_W-1:0] secret;
  logic                         letter_valid;
  logic [LETTER_W-1:0]          letter;
  logic                         backspace;
  logic                         submit;

  logic                         q_I, q_Entry, q_Score, q_Result, q_Done;
  logic [WORD_LEN*LETTER_W-1:0] guess;
  logic [CW-1:0]                letter_count;
  logic [3:0]                   guess_num;
  logic [2*WORD_LEN-1:0]        feedback;
  logic                         feedback_valid;
  logic                         win, lose;

  modport master (
    output Start, Ack, secret, letter_valid, letter, backspace, submit,
    input  q_I, q_Entry, q_Score, q_Result, q_Done, guess, letter_count,
           guess_num, feedback, feedback_valid, win, lose
  );

  modport slave (
    input  Start, Ack, secret, letter_valid, letter, backspace, submit,
    output q_I, q_Entry, q_Score, q_Result, q_Done, guess, letter_count,
           guess_num, feedback, feedback_valid, win, lose
  );
endinterface

// File: rtl/wordle_game_ctrl.sv
// Wordle game controller: letter entry with backspace, two-pass serial scoring
// (exact matches first, then leftmost unused secret letter), win/lose tracking.
module wordle_game_ctrl #(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 8
) (
  input logic          Clk,
  input logic          reset,
  wordle_game_ctrl_if.slave bus
);
  localparam int CW = $clog2(WORD_LEN+1);
  localparam int IW = $clog2(WORD_LEN);

  typedef enum logic [2:0] {QI, QENTRY, QSCORE, QRESULT, QDONE} state_t;
  state_t state, state_nxt;

  logic [WORD_LEN-1:0][LETTER_W-1:0] secret_q, guess_q;
  logic [WORD_LEN-1:0][1:0]          fb_q;
  logic [WORD_LEN-1:0]               used;
  logic [CW-1:0]                     letter_count;
  logic [3:0]                        guess_num;
  logic [IW-1:0]                     idx;
  logic                              phase;
  logic                              win, lose;

  logic          last_idx, full, all_exact, match_found;
  logic [IW-1:0] match_j;

  assign last_idx = (idx == IW'(WORD_LEN-1));
  assign full     = (letter_count == CW'(WORD_LEN));

  // Leftmost unused secret position holding the letter under test;
  // scanning downward lets the lowest index overwrite the others.
  always_comb begin
    all_exact   = 1'b1;
    match_found = 1'b0;
    match_j     = '0;
    for (int k = 0; k < WORD_LEN; k++)
      if (fb_q[k] != 2'b10) all_exact = 1'b0;
    for (int j = WORD_LEN-1; j >= 0; j--)
      if (!used[j] && secret_q[j] == guess_q[idx]) begin
        match_found = 1'b1;
        match_j     = IW'(j);
      end
  end

  always_ff @(posedge Clk or negedge reset)
    if (!reset) state <= QI;
    else        state <= state_nxt;

  always_comb begin
    state_nxt          = state;
    bus.q_I            = 1'b0;
    bus.q_Entry        = 1'b0;
    bus.q_Score        = 1'b0;
    bus.q_Result       = 1'b0;
    bus.q_Done         = 1'b0;
    bus.feedback_valid = 1'b0;
    case (state)
      QI: begin
        bus.q_I = 1'b1;
        if (bus.Start) state_nxt = QENTRY;
      end
      QENTRY: begin
        bus.q_Entry = 1'b1;
        if (bus.submit && full) state_nxt = QSCORE;
      end
      QSCORE: begin
        bus.q_Score = 1'b1;
        if (phase && last_idx) state_nxt = QRESULT;
      end
      QRESULT: begin
        bus.q_Result       = 1'b1;
        bus.feedback_valid = 1'b1;
        if (bus.Ack) state_nxt = (win || lose) ? QDONE : QENTRY;
      end
      QDONE: begin
        bus.q_Done = 1'b1;
        if (bus.Ack) state_nxt = QI;
      end
      default: state_nxt = QI;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      secret_q     <= '0;
      guess_q      <= '0;
      fb_q         <= '0;
      used         <= '0;
      letter_count <= '0;
      guess_num    <= '0;
      idx          <= '0;
      phase        <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      case (state)
        QI: if (bus.Start) begin
          secret_q     <= bus.secret;
          guess_q      <= '0;
          letter_count <= '0;
          guess_num    <= '0;
          fb_q         <= '0;
          win          <= 1'b0;
          lose         <= 1'b0;
        end
        QENTRY: begin
          if (bus.submit && full) begin
            guess_num <= guess_num + 4'd1;
            used      <= '0;
            idx       <= '0;
            phase     <= 1'b0;
          end else if (bus.backspace && letter_count != '0) begin
            letter_count <= letter_count - 1'b1;
            for (int k = 0; k < WORD_LEN; k++)
              if (CW'(k) == letter_count - 1'b1) guess_q[k] <= '0;
          end else if (bus.letter_valid && !full) begin
            letter_count <= letter_count + 1'b1;
            for (int k = 0; k < WORD_LEN; k++)
              if (CW'(k) == letter_count) guess_q[k] <= bus.letter;
          end
        end
        QSCORE: begin
          idx <= last_idx ? '0 : idx + 1'b1;
          if (!phase) begin
            if (guess_q[idx] == secret_q[idx]) begin
              fb_q[idx] <= 2'b10;
              used[idx] <= 1'b1;
            end else begin
              fb_q[idx] <= 2'b00;
            end
            if (last_idx) phase <= 1'b1;
          end else begin
            if (fb_q[idx] != 2'b10 && match_found) begin
              fb_q[idx]     <= 2'b01;
              used[match_j] <= 1'b1;
            end
            // Phase 2 never creates or removes an exact match, so all_exact is final here.
            if (last_idx) begin
              win  <= all_exact;
              lose <= !all_exact && (guess_num == 4'(MAX_GUESSES));
            end
          end
        end
        QRESULT: if (bus.Ack && !(win || lose)) begin
          guess_q      <= '0;
          letter_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.guess        = guess_q;
  assign bus.letter_count = letter_count;
  assign bus.guess_num    = guess_num;
  assign bus.feedback     = fb_q;
  assign bus.win          = win;
  assign bus.lose         = lose;
endmodule
